// File: rtl/led_bank_driver.sv
// Front-panel LED bank driver: pattern register, PWM dimming and blink,
// driven true or inverted onto tri-stateable pins gated by two active-low enables.
`timescale 1ns/1ps
module led_bank_driver #(
   parameter int WIDTH     = 8,
   parameter int INVERT    = 1,
   parameter int PWM_BITS  = 4,
   parameter int BLINK_DIV = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WIDTH-1:0]    d,
   input  logic                load,
   input  logic                oe1_n,
   input  logic                oe2_n,
   input  logic [PWM_BITS-1:0] brightness,
   input  logic                blink_en,
   output logic [WIDTH-1:0]    y,
   output logic                pwm_wrap
);

   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
   localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [WIDTH-1:0]    pat;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PWM_BITS-1:0] bright_q;
   logic [BW-1:0]       blink_cnt;
   logic                blink_ph;
   logic                pwm_on;
   logic                oe;
   logic [WIDTH-1:0]    lit;
   logic [WIDTH-1:0]    pins;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat       <= '0;
         pwm_cnt   <= '0;
         bright_q  <= '1;
         blink_cnt <= '0;
         blink_ph  <= 1'b1;
      end else begin
         if (load)
            pat <= d;
         pwm_cnt <= pwm_cnt + 1'b1;
         // duty only changes on a period boundary so a period is never split
         if (pwm_wrap)
            bright_q <= brightness;
         if (!blink_en) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
         end else if (pwm_wrap) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt <= '0;
               blink_ph  <= ~blink_ph;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end
   end

   assign pwm_wrap = (pwm_cnt == PWM_MAX);
   assign pwm_on   = (bright_q == PWM_MAX) || (pwm_cnt < bright_q);
   assign lit      = pat & {WIDTH{pwm_on & (blink_ph | ~blink_en)}};
   assign oe       = ~oe1_n & ~oe2_n;
   assign pins     = (INVERT != 0) ? ~lit : lit;
   assign y        = oe ? pins : {WIDTH{1'bz}};

endmodule

// File: tb/tb_led_bank_driver.sv
// Directed self-checking bench for led_bank_driver (WIDTH=8, INVERT=1,
// PWM_BITS=4, BLINK_DIV=2 so blink phases are 32 clocks).
`timescale 1ns/1ps
module tb_led_bank_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] d;
   logic       load;
   logic       oe1_n;
   logic       oe2_n;
   logic [3:0] brightness;
   logic       blink_en;
   logic [7:0] y;
   logic       pwm_wrap;

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] mcnt;

   led_bank_driver #(.WIDTH(8), .INVERT(1), .PWM_BITS(4), .BLINK_DIV(2)) dut (
      .clk(clk), .rst_n(rst_n), .d(d), .load(load), .oe1_n(oe1_n),
      .oe2_n(oe2_n), .brightness(brightness), .blink_en(blink_en),
      .y(y), .pwm_wrap(pwm_wrap)
   );

   always #5 clk = ~clk;

   // reference PWM phase counter
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mcnt <= 4'd0;
      else        mcnt <= mcnt + 4'd1;
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_cnt(input logic [3:0] v);
      int n = 0;
      while (mcnt != v && n < 40) begin
         step();
         n++;
      end
      if (mcnt != v) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_cnt timeout: cnt=%0d want=%0d", mcnt, v);
      end
   endtask

   task automatic test_reset();
      int first;
      rst_n = 1'b0; d = 8'h00; load = 1'b0; oe1_n = 1'b0; oe2_n = 1'b0;
      brightness = 4'h0; blink_en = 1'b0;
      step(); step();
      n_cmp++;
      if (y !== 8'hFF || pwm_wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: y=%h wrap=%b want y=ff wrap=0", y, pwm_wrap);
      end
      rst_n = 1'b1;
      d = 8'hC3; load = 1'b1;
      step();
      load = 1'b0;
      repeat (6) step();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (y !== 8'hFF || pwm_wrap !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_midrun: y=%h wrap=%b want y=ff wrap=0", y, pwm_wrap);
      end
      @(negedge clk);
      rst_n = 1'b1;
      first = 0;
      for (int i = 1; i <= 40 && first == 0; i++) begin
         step();
         if (pwm_wrap === 1'b1) first = i;
      end
      n_cmp++;
      if (first != 15) begin
         n_bad++;
         $display("FAIL first_wrap: after %0d edges want 15", first);
      end
   endtask

   task automatic test_load();
      d = 8'hA5; load = 1'b1; brightness = 4'hF;
      step();
      load = 1'b0; d = 8'h00;
      for (int i = 0; i < 20; i++) begin
         n_cmp++;
         if (y !== 8'h5A || pwm_wrap !== (mcnt == 4'd15)) begin
            n_bad++;
            $display("FAIL load_hold[%0d]: y=%h wrap=%b want y=5a wrap=%b",
                     i, y, pwm_wrap, mcnt == 4'd15);
         end
         step();
      end
   endtask

   task automatic test_pwm();
      logic [7:0] exp;
      d = 8'h01; load = 1'b1;
      step();
      load = 1'b0;
      brightness = 4'd4;
      wait_cnt(4'd15);
      for (int k = 0; k < 16; k++) begin
         step();
         exp = (k < 4) ? 8'hFE : 8'hFF;
         n_cmp++;
         if (y !== exp) begin
            n_bad++;
            $display("FAIL pwm4[%0d]: y=%h want %h", k, y, exp);
         end
      end
      brightness = 4'd0;
      for (int k = 0; k < 16; k++) begin
         step();
         n_cmp++;
         if (y !== 8'hFF) begin
            n_bad++;
            $display("FAIL pwm0[%0d]: y=%h want ff", k, y);
         end
      end
   endtask

   task automatic test_midchange();
      logic [7:0] exp;
      brightness = 4'd4;
      wait_cnt(4'd15);
      for (int k = 0; k < 16; k++) begin
         step();
         exp = (k < 4) ? 8'hFE : 8'hFF;
         n_cmp++;
         if (y !== exp) begin
            n_bad++;
            $display("FAIL mid_old[%0d]: y=%h want %h", k, y, exp);
         end
         if (k == 5) brightness = 4'd12;
      end
      for (int k = 0; k < 16; k++) begin
         step();
         exp = (k < 12) ? 8'hFE : 8'hFF;
         n_cmp++;
         if (y !== exp) begin
            n_bad++;
            $display("FAIL mid_new[%0d]: y=%h want %h", k, y, exp);
         end
      end
   endtask

   task automatic test_blink();
      logic [7:0] exp;
      d = 8'hFF; load = 1'b1; brightness = 4'hF;
      step();
      load = 1'b0;
      wait_cnt(4'd15);
      step();
      blink_en = 1'b1;
      #1;
      for (int i = 0; i < 128; i++) begin
         if (i > 0) step();
         exp = (((i / 32) % 2) == 0) ? 8'h00 : 8'hFF;
         n_cmp++;
         if (y !== exp) begin
            n_bad++;
            $display("FAIL blink[%0d]: y=%h want %h", i, y, exp);
         end
      end
      blink_en = 1'b0;
      step();
      n_cmp++;
      if (y !== 8'h00) begin
         n_bad++;
         $display("FAIL blink_off: y=%h want 00", y);
      end
   endtask

   task automatic test_enables();
      logic [7:0] exp;
      d = 8'h81; load = 1'b1; brightness = 4'd8;
      step();
      load = 1'b0;
      wait_cnt(4'd15);
      for (int k = 0; k < 32; k++) begin
         step();
         oe1_n = (k >= 5 && k <= 9);
         oe2_n = (k >= 20 && k <= 24);
         #1;
         if (oe1_n || oe2_n) exp = 8'bzzzz_zzzz;
         else                exp = ((k % 16) < 8) ? 8'h7E : 8'hFF;
         n_cmp++;
         if (y !== exp) begin
            n_bad++;
            $display("FAIL enable[%0d]: y=%h want %h", k, y, exp);
         end
      end
      oe1_n = 1'b0; oe2_n = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_pwm();
      test_midchange();
      test_blink();
      test_enables();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
